// File: rtl/lsq_mem_responder_if.sv
`default_nettype none
// ============================================================================
//  Module   : lsq_mem_responder_if
//  Function : LSQ memory-port request/response bus. Optional err_out member
//             exists when LSQ_MEMRESP_MISALIGN_ERR_EN is defined.
//  Revision : 1.0  initial release
// ============================================================================
interface lsq_mem_responder_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int ID_W   = 4
);
    logic              valid_in;
    logic              rw_in;
    logic [ADDR_W-1:0] addr_in;
    logic [DATA_W-1:0] data_in;
    logic [ID_W-1:0]   ldstID_in;
    logic              stall_out;
    logic              ready_out;
    logic [DATA_W-1:0] data_out;
    logic [ID_W-1:0]   ldstID_out;
`ifdef LSQ_MEMRESP_MISALIGN_ERR_EN
    logic              err_out;
`endif

    modport master (
        output valid_in, rw_in, addr_in, data_in, ldstID_in,
        input  stall_out, ready_out, data_out, ldstID_out
`ifdef LSQ_MEMRESP_MISALIGN_ERR_EN
        , input err_out
`endif
    );

    modport slave (
        input  valid_in, rw_in, addr_in, data_in, ldstID_in,
        output stall_out, ready_out, data_out, ldstID_out
`ifdef LSQ_MEMRESP_MISALIGN_ERR_EN
        , output err_out
`endif
    );
endinterface
`default_nettype wire

// File: rtl/lsq_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : lsq_mem_responder
//  Function : In-order, fixed-latency memory responder for the LSQ port with a
//             request queue and word-addressed array. Optional misaligned-access
//             error reporting via macro LSQ_MEMRESP_MISALIGN_ERR_EN.
//  Revision : 1.0  initial release
// ============================================================================
module lsq_mem_responder #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int ID_W      = 4,
    parameter int MEM_WORDS = 1024,
    parameter int LATENCY   = 4,
    parameter int QDEPTH    = 4
) (
    input  wire logic          clk,
    input  wire logic          rst,
    lsq_mem_responder_if.slave bus
);
    localparam int c_idx_w = $clog2(MEM_WORDS);
    localparam int c_ptr_w = $clog2(QDEPTH);
    localparam int c_cnt_w = $clog2(LATENCY) + 1;
    localparam logic [c_ptr_w:0]   c_full     = (c_ptr_w + 1)'(QDEPTH);
    localparam logic [c_cnt_w-1:0] c_cnt_init = c_cnt_w'(LATENCY - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic               r_q_rw   [QDEPTH];
    logic [c_idx_w-1:0] r_q_idx  [QDEPTH];
    logic [DATA_W-1:0]  r_q_data [QDEPTH];
    logic [ID_W-1:0]    r_q_id   [QDEPTH];
    logic [c_ptr_w-1:0] r_wptr;
    logic [c_ptr_w-1:0] r_rptr;
    logic [c_ptr_w:0]   r_count;

    logic               r_svc_rw;
    logic [c_idx_w-1:0] r_svc_idx;
    logic [DATA_W-1:0]  r_svc_data;
    logic [ID_W-1:0]    r_svc_id;
    logic [c_cnt_w-1:0] r_cnt;

    logic [DATA_W-1:0]  r_mem [MEM_WORDS];
    logic [DATA_W-1:0]  r_data_out;
    logic [ID_W-1:0]    r_id_out;

    logic               w_stall;
    logic               w_push;
    logic               w_pop;
    logic               w_done;
    logic               w_wr;
    logic [DATA_W-1:0]  w_rd_data;
    logic               w_unused;

`ifdef LSQ_MEMRESP_MISALIGN_ERR_EN
    logic               r_q_mis [QDEPTH];
    logic               r_svc_mis;

    assign w_unused = &{1'b0, bus.addr_in[ADDR_W-1:c_idx_w+2]};
`else
    assign w_unused = &{1'b0, bus.addr_in[ADDR_W-1:c_idx_w+2], bus.addr_in[1:0]};
`endif

    // Full is judged on the registered count only, so a same-cycle pop never
    // opens a slot for the incoming request.
    assign w_stall = (r_count == c_full);
    assign w_push  = bus.valid_in && !w_stall;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_rw[r_wptr]   <= bus.rw_in;
            r_q_idx[r_wptr]  <= bus.addr_in[c_idx_w+1:2];
            r_q_data[r_wptr] <= bus.data_in;
            r_q_id[r_wptr]   <= bus.ldstID_in;
`ifdef LSQ_MEMRESP_MISALIGN_ERR_EN
            r_q_mis[r_wptr]  <= |bus.addr_in[1:0];
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_count != '0) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_BUSY;
                end
            end
            S_BUSY: begin
                if (r_cnt == c_cnt_last) begin
                    w_done      = 1'b1;
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (r_count != '0) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_BUSY;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_svc_rw   <= 1'b0;
            r_svc_idx  <= '0;
            r_svc_data <= '0;
            r_svc_id   <= '0;
            r_cnt      <= '0;
`ifdef LSQ_MEMRESP_MISALIGN_ERR_EN
            r_svc_mis  <= 1'b0;
`endif
        end else if (w_pop) begin
            r_svc_rw   <= r_q_rw[r_rptr];
            r_svc_idx  <= r_q_idx[r_rptr];
            r_svc_data <= r_q_data[r_rptr];
            r_svc_id   <= r_q_id[r_rptr];
            r_cnt      <= c_cnt_init;
`ifdef LSQ_MEMRESP_MISALIGN_ERR_EN
            r_svc_mis  <= r_q_mis[r_rptr];
`endif
        end else if (r_state == S_BUSY) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // The access commits on the edge that enters RESP, so the array is already
    // updated before the next queued request can be popped.
    always_comb begin
        w_rd_data = r_svc_rw ? r_svc_data : r_mem[r_svc_idx];
        w_wr      = w_done && r_svc_rw;
`ifdef LSQ_MEMRESP_MISALIGN_ERR_EN
        if (r_svc_mis) begin
            w_wr = 1'b0;
            if (!r_svc_rw) w_rd_data = DATA_W'(32'hDEADBEEF);
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_svc_idx] <= r_svc_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_data_out <= '0;
            r_id_out   <= '0;
        end else if (w_done) begin
            r_data_out <= w_rd_data;
            r_id_out   <= r_svc_id;
        end
    end

    assign bus.stall_out  = w_stall;
    assign bus.ready_out  = (r_state == S_RESP);
    assign bus.data_out   = r_data_out;
    assign bus.ldstID_out = r_id_out;
`ifdef LSQ_MEMRESP_MISALIGN_ERR_EN
    assign bus.err_out    = (r_state == S_RESP) && r_svc_mis;
`endif

endmodule
`default_nettype wire

// File: tb/tb_lsq_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lsq_mem_responder
//  Function : Directed bench for lsq_mem_responder with a timestamp/queue model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_lsq_mem_responder;
    localparam int DATA_W    = 32;
    localparam int ADDR_W    = 32;
    localparam int ID_W      = 4;
    localparam int MEM_WORDS = 1024;
    localparam int LATENCY   = 4;
    localparam int QDEPTH    = 4;

    logic clk = 1'b0;
    logic rst;

    lsq_mem_responder_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ID_W(ID_W)) bus ();

    lsq_mem_responder #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ID_W(ID_W),
        .MEM_WORDS(MEM_WORDS), .LATENCY(LATENCY), .QDEPTH(QDEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          rw;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  id;
        int          acc;
    } req_t;

    typedef struct {
        logic [3:0]  id;
        logic [31:0] data;
        bit          err;
        int          cyc;
    } rsp_t;

    req_t        pend[$];
    req_t        svc;
    bit          svc_v = 1'b0;
    int          svc_resp = 0;
    logic [31:0] mmem [int];
    int          cyc = 0;
    bit          m_acc = 1'b0;
    int          last_acc_cyc = 0;
    bit          e_ready = 1'b0;
    bit          e_dknown = 1'b1;
    logic [31:0] e_data = '0;
    logic [3:0]  e_id = '0;
`ifdef LSQ_MEMRESP_MISALIGN_ERR_EN
    bit          e_err = 1'b0;
`endif
    rsp_t        log_q[$];
    bit          saw_stall = 1'b0;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int widx(input logic [31:0] a);
        return int'((a >> 2) & (MEM_WORDS - 1));
    endfunction

    // Model: requests wait in a FIFO; service starts the edge after the
    // previous response (or after acceptance) and completes LATENCY-1 edges later.
    always @(posedge clk) begin
        int   pre;
        bit   mis;
        req_t r;
        cyc++;
        m_acc   = 1'b0;
        e_ready = 1'b0;
`ifdef LSQ_MEMRESP_MISALIGN_ERR_EN
        e_err   = 1'b0;
`endif
        pre = pend.size();
        if (!rst) begin
            pend.delete();
            svc_v    = 1'b0;
            e_data   = '0;
            e_id     = '0;
            e_dknown = 1'b1;
        end else begin
            if (svc_v && svc_resp < cyc) svc_v = 1'b0;
            if (!svc_v && pre > 0) begin
                svc      = pend.pop_front();
                svc_v    = 1'b1;
                svc_resp = cyc + LATENCY - 1;
            end
            if (bus.valid_in && pre != QDEPTH) begin
                r.rw   = bus.rw_in;
                r.addr = bus.addr_in;
                r.data = bus.data_in;
                r.id   = bus.ldstID_in;
                r.acc  = cyc;
                pend.push_back(r);
                m_acc  = 1'b1;
            end
            if (svc_v && svc_resp == cyc) begin
                mis = 1'b0;
`ifdef LSQ_MEMRESP_MISALIGN_ERR_EN
                mis   = (svc.addr[1:0] != 2'b00);
                e_err = mis;
`endif
                e_ready = 1'b1;
                e_id    = svc.id;
                if (svc.rw) begin
                    if (!mis) mmem[widx(svc.addr)] = svc.data;
                    e_data   = svc.data;
                    e_dknown = 1'b1;
                end else if (mis) begin
                    e_data   = 32'hDEADBEEF;
                    e_dknown = 1'b1;
                end else if (mmem.exists(widx(svc.addr))) begin
                    e_data   = mmem[widx(svc.addr)];
                    e_dknown = 1'b1;
                end else begin
                    e_dknown = 1'b0;
                end
            end
        end
        #1;
        chk("stall_out", {31'b0, bus.stall_out}, {31'b0, (pend.size() == QDEPTH)});
        chk("ready_out", {31'b0, bus.ready_out}, {31'b0, e_ready});
        if (e_dknown) chk("data_out", bus.data_out, e_data);
        chk("ldstID_out", {28'b0, bus.ldstID_out}, {28'b0, e_id});
`ifdef LSQ_MEMRESP_MISALIGN_ERR_EN
        chk("err_out", {31'b0, bus.err_out}, {31'b0, e_err});
`endif
        if (bus.stall_out) saw_stall = 1'b1;
        if (bus.ready_out) begin
            rsp_t s;
            s.id   = bus.ldstID_out;
            s.data = bus.data_out;
            s.cyc  = cyc;
            s.err  = 1'b0;
`ifdef LSQ_MEMRESP_MISALIGN_ERR_EN
            s.err  = bus.err_out;
`endif
            log_q.push_back(s);
        end
    end

    task automatic send(input bit rw, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] id);
        bit done;
        done = 1'b0;
        @(negedge clk);
        bus.valid_in  = 1'b1;
        bus.rw_in     = rw;
        bus.addr_in   = a;
        bus.data_in   = d;
        bus.ldstID_in = id;
        for (int i = 0; i < 64 && !done; i++) begin
            @(posedge clk);
            #2;
            if (m_acc) begin
                done = 1'b1;
                last_acc_cyc = cyc;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: id %0d never accepted, required within 64 cycles", id);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        bus.valid_in = 1'b0;
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(posedge clk);
            #2;
            if (pend.size() == 0 && (!svc_v || svc_resp < cyc)) done = 1'b1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: queue busy after 200 cycles, required empty");
        end
        repeat (2) @(posedge clk);
        #2;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b0;
        bus.valid_in  = 1'b0;
        bus.rw_in     = 1'b0;
        bus.addr_in   = '0;
        bus.data_in   = '0;
        bus.ldstID_in = '0;
        repeat (3) @(negedge clk);
        chk("reset_ready", {31'b0, bus.ready_out}, 32'd0);
        chk("reset_stall", {31'b0, bus.stall_out}, 32'd0);
        chk("reset_data", bus.data_out, 32'd0);
        chk("reset_id", {28'b0, bus.ldstID_out}, 32'd0);
        rst = 1'b1;

        // Test 1: stores then loads to the same words, in-order tags
        log_q.delete();
        send(1'b1, 32'd40, 32'd9000, 4'd1);
        send(1'b1, 32'd44, 32'd9001, 4'd2);
        send(1'b0, 32'd40, 32'd0,    4'd3);
        send(1'b0, 32'd44, 32'd0,    4'd4);
        idle();
        drain();
        chk("t1_count", 32'(log_q.size()), 32'd4);
        if (log_q.size() == 4) begin
            for (int i = 0; i < 4; i++) chk("t1_order", {28'b0, log_q[i].id}, 32'(i + 1));
            chk("t1_load40", log_q[2].data, 32'd9000);
            chk("t1_load44", log_q[3].data, 32'd9001);
        end

        // Test 2: single load latency into an idle block
        send(1'b1, 32'd0, 32'd0, 4'd0);
        idle();
        drain();
        log_q.delete();
        send(1'b0, 32'd0, 32'd0, 4'd5);
        begin
            int acc;
            acc = last_acc_cyc;
            idle();
            drain();
            chk("t2_count", 32'(log_q.size()), 32'd1);
            if (log_q.size() == 1) begin
                chk("t2_latency", 32'(log_q[0].cyc - acc), 32'd4);
                chk("t2_data", log_q[0].data, 32'd0);
                chk("t2_id", {28'b0, log_q[0].id}, 32'd5);
            end
        end

        // Test 3: back-to-back burst overfills the queue
        log_q.delete();
        saw_stall = 1'b0;
        for (int i = 0; i < 7; i++) send(1'b1, 32'(200 + 4 * i), 32'(100 + i), 4'(i));
        idle();
        drain();
        chk("t3_stall_seen", {31'b0, saw_stall}, 32'd1);
        chk("t3_count", 32'(log_q.size()), 32'd7);
        if (log_q.size() == 7)
            for (int i = 0; i < 7; i++) chk("t3_order", {28'b0, log_q[i].id}, 32'(i));

        // Test 4: store then load same word on consecutive edges
        log_q.delete();
        send(1'b1, 32'd8, 32'hA5, 4'd7);
        send(1'b0, 32'd8, 32'd0,  4'd8);
        idle();
        drain();
        chk("t4_count", 32'(log_q.size()), 32'd2);
        if (log_q.size() == 2) begin
            chk("t4_id", {28'b0, log_q[1].id}, 32'd8);
            chk("t4_data", log_q[1].data, 32'hA5);
        end

        // Test 5: asynchronous reset while busy with three queued
        log_q.delete();
        send(1'b0, 32'd40,  32'd0, 4'd1);
        send(1'b0, 32'd44,  32'd0, 4'd2);
        send(1'b0, 32'd200, 32'd0, 4'd3);
        send(1'b0, 32'd204, 32'd0, 4'd4);
        @(negedge clk);
        bus.valid_in = 1'b0;
        rst = 1'b0;
        #1;
        chk("t5_rst_ready", {31'b0, bus.ready_out}, 32'd0);
        chk("t5_rst_data", bus.data_out, 32'd0);
        chk("t5_rst_id", {28'b0, bus.ldstID_out}, 32'd0);
        chk("t5_rst_stall", {31'b0, bus.stall_out}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (12) @(posedge clk);
        #2;
        chk("t5_no_resp", 32'(log_q.size()), 32'd0);
        send(1'b0, 32'd40, 32'd0, 4'd9);
        idle();
        drain();
        chk("t5_count", 32'(log_q.size()), 32'd1);
        if (log_q.size() == 1) chk("t5_array_kept", log_q[0].data, 32'd9000);

`ifdef LSQ_MEMRESP_MISALIGN_ERR_EN
        // Test 6: misaligned store suppressed, misaligned load flagged
        log_q.delete();
        send(1'b1, 32'd42, 32'd7, 4'd9);
        send(1'b0, 32'd42, 32'd0, 4'd10);
        send(1'b0, 32'd40, 32'd0, 4'd11);
        idle();
        drain();
        chk("t6_count", 32'(log_q.size()), 32'd3);
        if (log_q.size() == 3) begin
            chk("t6_st_err", {31'b0, log_q[0].err}, 32'd1);
            chk("t6_ld_err", {31'b0, log_q[1].err}, 32'd1);
            chk("t6_ld_data", log_q[1].data, 32'hDEADBEEF);
            chk("t6_ok_err", {31'b0, log_q[2].err}, 32'd0);
            chk("t6_ok_data", log_q[2].data, 32'd9000);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
